// File: rtl/sweep_pulse_emitter_pkg.sv
// Shared constants for the sweep pulse emitter and pulse identifier: LFSR width,
// BMC bit timing, counter widths and the FSM state encodings.
package sweep_pulse_emitter_pkg;

  localparam int LFSR_W         = 17;
  localparam int BIT_TICKS_DEF  = 16;
  localparam int HALF_TICKS_DEF = 8;
  localparam int DELAY_W        = 16;
  localparam int BITCNT_W       = 8;
  localparam int TICK_W         = 4;
  localparam int NUM_CH         = 3;

  typedef enum logic {
    TOP_IDLE,
    TOP_RUN
  } top_state_e;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_WAIT,
    CH_EMIT,
    CH_FINISHED
  } ch_state_e;

  // Fibonacci step: shift left, feed back the parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] state,
                                                  input logic [LFSR_W-1:0] poly);
    return {state[LFSR_W-2:0], ^(state & poly)};
  endfunction

endpackage

// File: rtl/sweep_pulse_channel.sv
// One sensor channel: start delay, envelope window and BMC-encoded LFSR data.
// Loads its parameters on accept_i and parks in FINISHED until the sweep ends.
module sweep_pulse_channel
  import sweep_pulse_emitter_pkg::*;
#(
  parameter int BIT_TICKS  = BIT_TICKS_DEF,
  parameter int HALF_TICKS = HALF_TICKS_DEF
) (
  input  logic                clk_96MHz,
  input  logic                reset,
  input  logic                accept_i,
  input  logic                sweep_end_i,
  input  logic [LFSR_W-1:0]   polynomial_i,
  input  logic [LFSR_W-1:0]   seed_i,
  input  logic [DELAY_W-1:0]  delay_i,
  input  logic [BITCNT_W-1:0] pulse_bits_i,
  output logic                envelope_o,
  output logic                data_o,
  output logic                finished_o
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [TICK_W-1:0] HALF_PRE  = TICK_W'(HALF_TICKS - 1);

  ch_state_e            state_q, state_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [BITCNT_W-1:0]  bits_q, bits_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]    poly_q, poly_d;
  logic                 data_q, data_d;

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state_q <= CH_IDLE;
      delay_q <= '0;
      bits_q  <= '0;
      tick_q  <= '0;
      lfsr_q  <= '0;
      poly_q  <= '0;
      data_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      bits_q  <= bits_d;
      tick_q  <= tick_d;
      lfsr_q  <= lfsr_d;
      poly_q  <= poly_d;
      data_q  <= data_d;
    end
  end

  // data_d is the level for the next cycle, so the first bit's 0->1 edge
  // coincides with the envelope rising.
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    bits_d  = bits_q;
    tick_d  = tick_q;
    lfsr_d  = lfsr_q;
    poly_d  = poly_q;
    data_d  = data_q;

    if (accept_i) begin
      lfsr_d  = seed_i;
      poly_d  = polynomial_i;
      bits_d  = pulse_bits_i;
      tick_d  = '0;
      data_d  = 1'b0;
      delay_d = '0;
      if (delay_i != '0) begin
        state_d = CH_WAIT;
        delay_d = delay_i - 1'b1;
      end else if (pulse_bits_i == '0) begin
        state_d = CH_FINISHED;
      end else begin
        state_d = CH_EMIT;
        data_d  = 1'b1;
      end
    end else begin
      case (state_q)
        CH_WAIT: begin
          if (delay_q != '0) begin
            delay_d = delay_q - 1'b1;
          end else if (bits_q == '0) begin
            state_d = CH_FINISHED;
          end else begin
            state_d = CH_EMIT;
            tick_d  = '0;
            data_d  = 1'b1;
          end
        end
        CH_EMIT: begin
          if (tick_q == TICK_LAST) begin
            lfsr_d = lfsr_step(lfsr_q, poly_q);
            tick_d = '0;
            if (bits_q == BITCNT_W'(1)) begin
              state_d = CH_FINISHED;
              bits_d  = '0;
              data_d  = 1'b0;
            end else begin
              bits_d = bits_q - 1'b1;
              data_d = ~data_q;
            end
          end else begin
            tick_d = tick_q + 1'b1;
            if (tick_q == HALF_PRE && lfsr_q[LFSR_W-1]) begin
              data_d = ~data_q;
            end
          end
        end
        CH_FINISHED: begin
          if (sweep_end_i) begin
            state_d = CH_IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign envelope_o = (state_q == CH_EMIT);
  assign data_o     = data_q;
  assign finished_o = (state_q == CH_FINISHED);

endmodule

// File: rtl/sweep_pulse_emitter.sv
// Three-channel sweep pulse emitter: a top RUN/IDLE controller that starts
// three delayed BMC pulse channels and reports completion with a done pulse.
module sweep_pulse_emitter
  import sweep_pulse_emitter_pkg::*;
#(
  parameter int BIT_TICKS  = BIT_TICKS_DEF,
  parameter int HALF_TICKS = HALF_TICKS_DEF
) (
  input  logic        clk_96MHz,
  input  logic        reset,
  input  logic        start,
  input  logic [16:0] polynomial,
  input  logic [16:0] lfsr_start,
  input  logic [15:0] delay_0,
  input  logic [15:0] delay_1,
  input  logic [15:0] delay_2,
  input  logic [7:0]  pulse_bits,
  output logic        envelop_wire_0,
  output logic        envelop_wire_1,
  output logic        envelop_wire_2,
  output logic        data_wire_0,
  output logic        data_wire_1,
  output logic        data_wire_2,
  output logic        busy,
  output logic        done
);

  top_state_e          state_q, state_d;
  logic                accept;
  logic                all_finished;
  logic [DELAY_W-1:0]  delay_arr [NUM_CH];
  logic [NUM_CH-1:0]   env_vec;
  logic [NUM_CH-1:0]   data_vec;
  logic [NUM_CH-1:0]   fin_vec;

  assign delay_arr[0] = delay_0;
  assign delay_arr[1] = delay_1;
  assign delay_arr[2] = delay_2;

  assign all_finished = &fin_vec;
  assign accept       = start && !busy;

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state_q <= TOP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // done and busy are decoded from the current state so that done lands in
  // the first cycle all channels report FINISHED, with busy already low.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      TOP_IDLE: begin
        if (start) begin
          state_d = TOP_RUN;
        end
      end
      TOP_RUN: begin
        if (all_finished) begin
          done    = 1'b1;
          state_d = start ? TOP_RUN : TOP_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: begin
        state_d = TOP_IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    sweep_pulse_channel #(
      .BIT_TICKS  (BIT_TICKS),
      .HALF_TICKS (HALF_TICKS)
    ) u_ch (
      .clk_96MHz    (clk_96MHz),
      .reset        (reset),
      .accept_i     (accept),
      .sweep_end_i  (done),
      .polynomial_i (polynomial),
      .seed_i       (lfsr_start),
      .delay_i      (delay_arr[gi]),
      .pulse_bits_i (pulse_bits),
      .envelope_o   (env_vec[gi]),
      .data_o       (data_vec[gi]),
      .finished_o   (fin_vec[gi])
    );
  end

  assign envelop_wire_0 = env_vec[0];
  assign envelop_wire_1 = env_vec[1];
  assign envelop_wire_2 = env_vec[2];
  assign data_wire_0    = data_vec[0];
  assign data_wire_1    = data_vec[1];
  assign data_wire_2    = data_vec[2];

endmodule

// File: tb/tb_sweep_pulse_emitter.sv
// Bench for sweep_pulse_emitter: cycle-accurate arithmetic model of envelope,
// BMC data, busy and done, plus directed literal timing/encoding checks.
module tb_sweep_pulse_emitter;

  localparam int BT = 16;
  localparam int HT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [16:0] polynomial = '0;
  logic [16:0] lfsr_start = '0;
  logic [15:0] delay_0 = '0, delay_1 = '0, delay_2 = '0;
  logic [7:0]  pulse_bits = '0;
  logic        envelop_wire_0, envelop_wire_1, envelop_wire_2;
  logic        data_wire_0, data_wire_1, data_wire_2;
  logic        busy, done;

  sweep_pulse_emitter dut (
    .clk_96MHz      (clk),
    .reset          (reset),
    .start          (start),
    .polynomial     (polynomial),
    .lfsr_start     (lfsr_start),
    .delay_0        (delay_0),
    .delay_1        (delay_1),
    .delay_2        (delay_2),
    .pulse_bits     (pulse_bits),
    .envelop_wire_0 (envelop_wire_0),
    .envelop_wire_1 (envelop_wire_1),
    .envelop_wire_2 (envelop_wire_2),
    .data_wire_0    (data_wire_0),
    .data_wire_1    (data_wire_1),
    .data_wire_2    (data_wire_2),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference model state: one accepted sweep described by its parameters.
  bit          m_active = 1'b0;
  int          m_n, m_pb, m_done;
  int          m_d [3];
  logic [16:0] m_seed, m_poly;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Data level at offset t into the envelope: count BMC transitions so far.
  function automatic logic level(input int t, input logic [16:0] seed, input logic [16:0] poly);
    logic [16:0] s;
    int trans;
    s = seed;
    trans = 0;
    for (int j = 0; j < t / BT; j++) begin
      trans += 1 + int'(s[16]);
      s = {s[15:0], ^(s & poly)};
    end
    trans += 1;
    if ((t % BT) >= HT) trans += int'(s[16]);
    return trans[0];
  endfunction

  // {busy, done, env0, env1, env2, data0, data1, data2}
  function automatic logic [7:0] expected(input int c);
    logic [7:0] v;
    int lo, hi;
    v = '0;
    if (m_active) begin
      v[7] = (c >= m_n + 1) && (c < m_done);
      v[6] = (c == m_done);
      for (int k = 0; k < 3; k++) begin
        lo = m_n + 1 + m_d[k];
        hi = m_n + m_d[k] + BT * m_pb;
        if (c >= lo && c <= hi) begin
          v[5-k] = 1'b1;
          v[2-k] = level(c - lo, m_seed, m_poly);
        end
      end
    end
    return v;
  endfunction

  initial begin : compare_proc
    bit valid;
    int shown;
    int mx;
    logic [7:0] exp_v, act_v;
    valid = 1'b0;
    shown = 0;
    forever begin
      @(negedge clk);
      act_v = {busy, done, envelop_wire_0, envelop_wire_1, envelop_wire_2,
               data_wire_0, data_wire_1, data_wire_2};
      exp_v = expected(cyc);
      if (valid) begin
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          if (shown < 20) $display("FAIL model_cmp cycle=%0d actual=%b required=%b", cyc, act_v, exp_v);
          shown++;
        end
      end
      if (reset) begin
        m_active = 1'b0;
        valid = 1'b1;
      end else if (start && !exp_v[7]) begin
        m_active = 1'b1;
        m_n = cyc;
        m_d[0] = int'(delay_0);
        m_d[1] = int'(delay_1);
        m_d[2] = int'(delay_2);
        m_pb = int'(pulse_bits);
        m_seed = lfsr_start;
        m_poly = polynomial;
        mx = m_d[0];
        if (m_d[1] > mx) mx = m_d[1];
        if (m_d[2] > mx) mx = m_d[2];
        m_done = m_n + 1 + mx + BT * m_pb;
        $display("sweep accepted cycle=%0d delays=%0d/%0d/%0d bits=%0d seed=%h poly=%h done_at=%0d",
                 m_n, m_d[0], m_d[1], m_d[2], m_pb, m_seed, m_poly, m_done);
      end else if (m_active && cyc >= m_done) begin
        m_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int c);
    do @(negedge clk); while (cyc < c);
    #1;
  endtask

  task automatic launch(input int d0, input int d1, input int d2, input int pb,
                        input logic [16:0] seed, input logic [16:0] poly, output int n);
    tick();
    delay_0 = 16'(d0);
    delay_1 = 16'(d1);
    delay_2 = 16'(d2);
    pulse_bits = 8'(pb);
    lfsr_start = seed;
    polynomial = poly;
    start = 1'b1;
    n = cyc;
    tick();
    start = 1'b0;
  endtask

  initial begin : stim_proc
    int n, n2, mx, len, w;
    int d0, d1, d2, pb;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    at(cyc);
    chk("reset_state", {busy, done, envelop_wire_0, envelop_wire_1, envelop_wire_2,
                        data_wire_0, data_wire_1, data_wire_2}, 8'h00);

    // Model pins: seed 10000 / poly 1 gives bits 1,0,0,0.
    chk("model_lvl_t0", level(0, 17'h10000, 17'h00001), 1);
    chk("model_lvl_t8", level(8, 17'h10000, 17'h00001), 0);
    chk("model_lvl_t16", level(16, 17'h10000, 17'h00001), 1);
    chk("model_lvl_t32", level(32, 17'h10000, 17'h00001), 0);

    // Timing: delays 10/20/30, 4 bits.
    launch(10, 20, 30, 4, 17'h1ACE1, 17'h12000, n);
    at(n + 1);  chk("t_busy_n1", busy, 1);
    at(n + 10); chk("t_env0_n10", envelop_wire_0, 0);
    at(n + 11); chk("t_env0_n11", envelop_wire_0, 1);
    at(n + 21); chk("t_env1_n21", envelop_wire_1, 1);
    at(n + 31); chk("t_env2_n31", envelop_wire_2, 1);
    at(n + 74); chk("t_env0_n74", envelop_wire_0, 1);
    at(n + 75); chk("t_env0_n75", envelop_wire_0, 0);
    at(n + 84); chk("t_env1_n84", envelop_wire_1, 1);
    at(n + 85); chk("t_env1_n85", envelop_wire_1, 0);
    at(n + 94); chk("t_env2_n94", envelop_wire_2, 1); chk("t_busy_n94", busy, 1); chk("t_done_n94", done, 0);
    at(n + 95); chk("t_done_n95", done, 1); chk("t_busy_n95", busy, 0); chk("t_env2_n95", envelop_wire_2, 0);
    at(n + 96); chk("t_done_n96", done, 0);
    repeat (3) tick();

    // Encoding: bits 1,0,0,0 on data_wire_0.
    launch(0, 0, 0, 4, 17'h10000, 17'h00001, n);
    at(n + 1);  chk("e_n1", data_wire_0, 1);
    at(n + 8);  chk("e_n8", data_wire_0, 1);
    at(n + 9);  chk("e_n9", data_wire_0, 0);
    at(n + 17); chk("e_n17", data_wire_0, 1);
    at(n + 32); chk("e_n32", data_wire_0, 1);
    at(n + 33); chk("e_n33", data_wire_0, 0);
    at(n + 48); chk("e_n48", data_wire_0, 0);
    at(n + 49); chk("e_n49", data_wire_0, 1);
    at(n + 64); chk("e_n64", data_wire_0, 1);
    at(n + 65); chk("e_n65", data_wire_0, 0); chk("e_env_n65", envelop_wire_0, 0); chk("e_done_n65", done, 1);
    repeat (3) tick();

    // Second start while busy is ignored.
    launch(10, 20, 30, 4, 17'h0BEEF, 17'h10004, n);
    at(n + 39);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    at(n + 74); chk("r_env0_n74", envelop_wire_0, 1);
    at(n + 75); chk("r_env0_n75", envelop_wire_0, 0);
    at(n + 95); chk("r_done_n95", done, 1);
    at(n + 96); chk("r_done_n96", done, 0); chk("r_busy_n96", busy, 0);
    repeat (3) tick();

    // Reset mid-emit, then a fresh sweep.
    launch(10, 20, 30, 4, 17'h15555, 17'h10100, n);
    at(n + 49);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    at(n + 51);
    chk("rst_outputs_n51", {busy, done, envelop_wire_0, envelop_wire_1, envelop_wire_2,
                            data_wire_0, data_wire_1, data_wire_2}, 8'h00);
    at(n + 59);
    launch(10, 20, 30, 4, 17'h15555, 17'h10100, n2);
    chk("rst_restart_n", n2, n + 60);
    at(n2 + 11); chk("rst_env0_rise", envelop_wire_0, 1);
    at(n2 + 95); chk("rst_done", done, 1);
    repeat (3) tick();

    // Zero pulse bits.
    launch(5, 0, 3, 0, 17'h1F00F, 17'h10010, n);
    at(n + 1); chk("z_busy_n1", busy, 1);
    at(n + 5); chk("z_done_n5", done, 0);
    at(n + 6); chk("z_done_n6", done, 1);
    chk("z_env_n6", {envelop_wire_0, envelop_wire_1, envelop_wire_2}, 3'b000);
    at(n + 7); chk("z_done_n7", done, 0);
    repeat (3) tick();

    // Randomized sweeps with stray starts and occasional resets.
    for (int r = 0; r < 40; r++) begin
      d0 = $urandom_range(0, 40);
      d1 = $urandom_range(0, 40);
      d2 = $urandom_range(0, 40);
      pb = $urandom_range(0, 6);
      launch(d0, d1, d2, pb, 17'($urandom), 17'($urandom), n);
      mx = d0;
      if (d1 > mx) mx = d1;
      if (d2 > mx) mx = d2;
      len = 1 + mx + BT * pb + 3;
      for (int i = 0; i < len; i++) begin
        tick();
        start = ($urandom_range(0, 5) == 0);
        reset = ($urandom_range(0, 199) == 0);
        delay_0 = 16'($urandom_range(0, 40));
        delay_1 = 16'($urandom_range(0, 40));
        delay_2 = 16'($urandom_range(0, 40));
        pulse_bits = 8'($urandom_range(0, 6));
        lfsr_start = 17'($urandom);
        polynomial = 17'($urandom);
      end
      tick();
      start = 1'b0;
      reset = 1'b0;
      w = 0;
      while ((busy || done) && w < 300) begin
        tick();
        w++;
      end
      chk("idle_wait", busy, 0);
      repeat (2) tick();
    end

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sweep_pulse_emitter.md
SWEEP_PULSE_EMITTER -- requirements
Module: sweep_pulse_emitter

Interface
REQ-001 Parameter BIT_TICKS, default 16, clk_96MHz cycles per BMC data bit (6 Mbit/s).
REQ-002 Parameter HALF_TICKS, default 8, cycle offset of the mid-bit transition within a bit.
REQ-003 clk_96MHz  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  single-cycle request to emit one sweep; sampled only when idle.
REQ-006 polynomial  in  17  LFSR feedback taps; latched on accepted start.
REQ-007 lfsr_start  in  17  LFSR seed; latched on accepted start.
REQ-008 delay_0, delay_1, delay_2  in  16 each  cycles from sweep begin to envelope rise, per sensor; latched on accepted start.
REQ-009 pulse_bits  in  8  LFSR bits per envelope pulse; latched on accepted start.
REQ-010 envelop_wire_0..2  out  1 each  per-sensor envelope, high while a pulse is emitted.
REQ-011 data_wire_0..2  out  1 each  per-sensor BMC-encoded LFSR data.
REQ-012 busy  out  1  high from the cycle after an accepted start until done.
REQ-013 done  out  1  one-cycle completion pulse.

Function
REQ-014 Start is accepted when start=1 and busy=0 in cycle N; busy=1 from N+1; start while busy=1 is ignored with no effect.
REQ-015 Top FSM states: IDLE -> RUN on accepted start; RUN -> IDLE when all three channels are FINISHED, asserting done and clearing busy in that same cycle.
REQ-016 Each channel FSM: IDLE -> WAIT on accepted start; WAIT -> EMIT after delay_k cycles; EMIT -> FINISHED after 16*pulse_bits cycles; FINISHED -> IDLE when the top FSM leaves RUN.
REQ-017 envelop_wire_k is high in cycles N+1+delay_k through N+delay_k+16*pulse_bits inclusive; low at all other times.
REQ-018 done is asserted in cycle N+1+max(delay_k)+16*pulse_bits, the first cycle all envelopes are low after the last pulse.
REQ-019 pulse_bits=0: no envelope is emitted; the channel enters FINISHED at N+1+delay_k.
REQ-020 delay_k=0: the envelope rises at N+1.
REQ-021 Each channel owns a 17-bit Fibonacci LFSR loaded with lfsr_start at accept; the output bit is state[16]; it advances once per emitted bit as next = {state[15:0], ^(state & polynomial)}.
REQ-022 All three channels emit the identical bit sequence starting from the same seed.
REQ-023 BMC: data_wire_k toggles at tick 0 of every bit, and additionally at tick HALF_TICKS when the bit is 1.
REQ-024 data_wire_k is 0 whenever envelop_wire_k is 0, so the first bit begins with a 0->1 edge and data is forced to 0 at envelope fall.
REQ-025 Degenerate inputs polynomial=0 and lfsr_start=0 are legal and emit 0 bits after the seed bit (no lockup handling).
REQ-026 Counters: delay 16-bit, bit count 8-bit, tick 4-bit; no counter wraps within a sweep.

Reset
REQ-027 When reset=1 at a clock edge, all FSMs go to IDLE and all outputs (envelop_wire_k, data_wire_k, busy, done) are 0 in the following cycle, including mid-sweep.
REQ-028 A start coincident with reset is ignored.
REQ-029 No state survives reset; the LFSR is reloaded only on the next accepted start.

Structure
REQ-030 LFSR width (17), BIT_TICKS, HALF_TICKS and the FSM state encodings live in a shared constants include used by both this block and pulse_identifier.
REQ-031 A single sub-module, sweep_pulse_channel, holds one channel's FSM, delay counter, LFSR and BMC encoder; it is instantiated three times.

Verification
REQ-032 Timing: start at N, delays 10/20/30, pulse_bits=4 -> envelopes high N+11..N+74, N+21..N+84 and N+31..N+94; done at N+95 only; busy high N+1..N+94.
REQ-033 Encoding: lfsr_start=17'h10000, polynomial=17'h00001, pulse_bits=4, delay 0 -> bits 1,0,0,0; data_wire_0 rises at N+1, falls at N+9, rises at N+17, falls at N+33, rises at N+49, forced 0 at N+65.
REQ-034 Loopback: emitter outputs drive triad_manager_sim with a known polynomial and seed -> pulse_identifier reports the same polynomial and consistent pulse_id values.
REQ-035 Start is pulsed again at N+40 during a busy sweep -> the waveforms are identical to the single-start case and only one done is produced.
REQ-036 Reset asserted at N+50 mid-emit -> all outputs are 0 at N+51 and no done occurs; a new start at N+60 produces a complete, correct sweep.
REQ-037 pulse_bits=0 with delays 5/0/3 -> envelopes stay low and done is asserted at N+6.
